// File: rtl/icmp_tx.sv
// ICMP echo-reply transmitter: builds preamble, Ethernet/IPv4/ICMP headers, echoed payload,
// zero padding and FCS, and drives them onto GMII one byte per cycle.
module icmp_tx #(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter int          IFG_CYCLES = 12,
  parameter int          MIN_DATA   = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start_en,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  input  logic [15:0] icmp_id,
  input  logic [15:0] icmp_seq,
  input  logic [31:0] reply_checksum,
  input  logic [15:0] tx_byte_num,
  output logic        tx_req,
  input  logic [7:0]  tx_data,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [3:0] {
    IDLE, CHKSUM, PREAMBLE, ETH_HEAD, IP_HEAD, ICMP_HEAD, TX_DATA, CRC, IFG
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q, ip_id_q, req_rem_q;
  logic        tx_req_q, gmii_tx_en_q, tx_busy_q, tx_done_q;
  logic [7:0]  gmii_txd_q;
  logic [47:0] des_mac_q;
  logic [31:0] des_ip_q, reply_sum_q, ip_sum_q, icmp_sum_q, crc_q;
  logic [15:0] icmp_id_q, icmp_seq_q, byte_num_q, ip_cks_q, icmp_cks_q;

  logic [15:0]  data_len_d, total_len_d;
  logic [31:0]  ip_sum_d, icmp_sum_d, crc_d;
  logic [111:0] eth_hdr_d;
  logic [159:0] ip_hdr_d;
  logic [63:0]  icmp_hdr_d;
  logic [7:0]   eth_byte_d, ip_byte_d, icmp_byte_d, pay_byte_d, crc_byte_d, emit_byte_d;

  // Byte-parallel reflected CRC-32: all eight bit steps resolve in one cycle.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign data_len_d  = (byte_num_q < 16'(MIN_DATA)) ? 16'(MIN_DATA) : byte_num_q;
  assign total_len_d = data_len_d + 16'd28;

  assign eth_hdr_d  = {des_mac_q, BOARD_MAC, 16'h0800};
  assign ip_hdr_d   = {16'h4500, total_len_d, ip_id_q, 16'h4000, 16'h8001, ip_cks_q,
                       BOARD_IP, des_ip_q};
  assign icmp_hdr_d = {16'h0000, icmp_cks_q, icmp_id_q, icmp_seq_q};

  // Header bytes are picked MSB-first by the byte counter.
  assign eth_byte_d  = 8'(eth_hdr_d >> (7'd104 - {cnt_q[3:0], 3'b000}));
  assign ip_byte_d   = 8'(ip_hdr_d >> (8'd152 - {cnt_q[4:0], 3'b000}));
  assign icmp_byte_d = 8'(icmp_hdr_d >> (6'd56 - {cnt_q[2:0], 3'b000}));
  assign pay_byte_d  = (cnt_q < byte_num_q) ? tx_data : 8'h00;
  assign crc_byte_d  = ~(8'(crc_q >> {cnt_q[1:0], 3'b000}));

  assign ip_sum_d = 32'h4500 + 32'(total_len_d) + 32'(ip_id_q) + 32'h4000 + 32'h8001
                  + 32'(BOARD_IP[31:16]) + 32'(BOARD_IP[15:0])
                  + 32'(des_ip_q[31:16]) + 32'(des_ip_q[15:0]);
  assign icmp_sum_d = 32'(icmp_id_q) + 32'(icmp_seq_q) + reply_sum_q;

  always_comb begin
    emit_byte_d = 8'h00;
    case (state_q)
      ETH_HEAD:  emit_byte_d = eth_byte_d;
      IP_HEAD:   emit_byte_d = ip_byte_d;
      ICMP_HEAD: emit_byte_d = icmp_byte_d;
      TX_DATA:   emit_byte_d = pay_byte_d;
      default:   emit_byte_d = 8'h00;
    endcase
  end

  assign crc_d = crc32_byte(crc_q, emit_byte_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ip_id_q      <= '0;
      req_rem_q    <= '0;
      tx_req_q     <= 1'b0;
      gmii_tx_en_q <= 1'b0;
      gmii_txd_q   <= '0;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (req_rem_q != '0) begin
        tx_req_q  <= 1'b1;
        req_rem_q <= req_rem_q - 16'd1;
      end else begin
        tx_req_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (tx_start_en) begin
            des_mac_q   <= des_mac;
            des_ip_q    <= des_ip;
            icmp_id_q   <= icmp_id;
            icmp_seq_q  <= icmp_seq;
            reply_sum_q <= reply_checksum;
            byte_num_q  <= tx_byte_num;
            tx_busy_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= CHKSUM;
          end
        end
        CHKSUM: begin
          case (cnt_q[1:0])
            2'd0: begin
              ip_sum_q   <= ip_sum_d;
              icmp_sum_q <= icmp_sum_d;
            end
            2'd1: begin
              ip_sum_q   <= 32'(ip_sum_q[31:16]) + 32'(ip_sum_q[15:0]);
              icmp_sum_q <= 32'(icmp_sum_q[31:16]) + 32'(icmp_sum_q[15:0]);
            end
            default: begin
              ip_cks_q   <= ~(ip_sum_q[31:16] + ip_sum_q[15:0]);
              icmp_cks_q <= ~(icmp_sum_q[31:16] + icmp_sum_q[15:0]);
            end
          endcase
          // The last checksum cycle already launches the first preamble byte.
          if (cnt_q == 16'd2) begin
            crc_q        <= 32'hFFFF_FFFF;
            gmii_tx_en_q <= 1'b1;
            gmii_txd_q   <= 8'h55;
            cnt_q        <= 16'd1;
            state_q      <= PREAMBLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        PREAMBLE: begin
          gmii_txd_q <= (cnt_q == 16'd7) ? 8'hD5 : 8'h55;
          if (cnt_q == 16'd7) begin
            cnt_q   <= '0;
            state_q <= ETH_HEAD;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ETH_HEAD, IP_HEAD, ICMP_HEAD, TX_DATA: begin
          gmii_txd_q <= emit_byte_d;
          crc_q      <= crc_d;
          cnt_q      <= cnt_q + 16'd1;
          // Requests run two cycles ahead of the payload bytes they fetch.
          if (state_q == ICMP_HEAD && cnt_q == 16'd6) begin
            tx_req_q  <= (byte_num_q != '0);
            req_rem_q <= (byte_num_q != '0) ? byte_num_q - 16'd1 : '0;
          end
          if (state_q == ETH_HEAD && cnt_q == 16'd13) begin
            cnt_q   <= '0;
            state_q <= IP_HEAD;
          end else if (state_q == IP_HEAD && cnt_q == 16'd19) begin
            cnt_q   <= '0;
            state_q <= ICMP_HEAD;
          end else if (state_q == ICMP_HEAD && cnt_q == 16'd7) begin
            cnt_q   <= '0;
            state_q <= TX_DATA;
          end else if (state_q == TX_DATA && cnt_q == data_len_d - 16'd1) begin
            cnt_q   <= '0;
            state_q <= CRC;
          end
        end
        CRC: begin
          gmii_txd_q <= crc_byte_d;
          if (cnt_q == 16'd3) begin
            cnt_q   <= '0;
            state_q <= IFG;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        IFG: begin
          if (cnt_q == '0) begin
            gmii_tx_en_q <= 1'b0;
            gmii_txd_q   <= '0;
            tx_done_q    <= 1'b1;
            ip_id_q      <= ip_id_q + 16'd1;
          end
          if (cnt_q == 16'(IFG_CYCLES)) begin
            tx_busy_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_req     = tx_req_q;
  assign gmii_tx_en = gmii_tx_en_q;
  assign gmii_txd   = gmii_txd_q;
  assign tx_busy    = tx_busy_q;
  assign tx_done    = tx_done_q;

endmodule
